// File: rtl/instr_fetch_pkg0.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg0
// Shared definitions for the instruction prefetcher: default port widths,
// word geometry (bytes per word, byte-offset bits) and the FIFO entry layout
// for the default configuration.
// ---------------------------------------------------------------------------
package instr_fetch_pkg0;

  localparam int ADDR_WIDTH_DEF   = 16;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int BYTES_PER_WORD   = DATA_WIDTH_DEF / 8;
  localparam int WORD_OFFSET_BITS = $clog2(BYTES_PER_WORD);

  // One buffered instruction: the byte address it was fetched from plus the
  // returned word.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } fifo_entry_t;

  // Fetch stride in bytes for an arbitrary word width.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/instr_fifo0.sv
// ---------------------------------------------------------------------------
// instr_fifo0
// Small synchronous FIFO used as the prefetch buffer.
//   clk, rst_n   : clock, synchronous active-low reset
//   flush_i      : drop all entries at the next edge (wins over push/pop)
//   push_i       : write push_data_i (accepted when not full, or full + pop)
//   pop_i        : retire the head entry (ignored when empty)
//   head_o       : current head entry (undefined while empty)
//   empty_o      : no entries held
//   count_o      : number of entries held, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module instr_fifo0 #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves the same
  // cycle, which keeps count unchanged.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem[wr_ptr] <= push_data_i;
  end

  // The issuer reserves a slot before requesting, so a push must never find
  // the buffer full without a simultaneous pop.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full && !pop_i && !flush_i));

endmodule

// File: rtl/instr_fetch_pref0.sv
// ---------------------------------------------------------------------------
// instr_fetch_pref0
// Instruction prefetcher on the initiator side of the instruction RAM port.
// Issues sequential word reads (1-cycle RAM latency), buffers returned words
// in instr_fifo0 and hands them to the core over valid/ready. A branch
// flushes buffered and in-flight data and refetches from the target.
//   clk, rst_n        : clock, synchronous active-low reset
//   fetch_en_i        : allow new requests
//   branch_i          : single-cycle redirect strobe
//   branch_addr_i     : redirect target (word-aligned internally)
//   instr_valid_o     : head word available
//   instr_ready_i     : core accepts head word
//   instr_rdata_o     : head word (0 while empty)
//   instr_addr_o      : head word byte address (0 while empty)
//   ram_en_o          : read request
//   ram_addr_o        : request byte address
//   ram_we_o, ram_be_o, ram_wdata_o : read-only ties
//   ram_rdata_i       : read data, valid the cycle after ram_en_o
// ---------------------------------------------------------------------------
module instr_fetch_pref0
  import instr_fetch_pkg0::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = {1'b1, {(ADDR_WIDTH-1){1'b0}}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_en_i,
  input  logic                    branch_i,
  input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  output logic [ADDR_WIDTH-1:0]   instr_addr_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int                    STRIDE     = bytes_per_word(DATA_WIDTH);
  localparam int                    CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A   = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRIDE - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] target;
  logic                  pop;
  logic                  push;
  logic                  room;
  logic [CW-1:0]         count;
  logic [CW:0]           occupancy;
  logic [CW:0]           limit;
  logic                  fifo_empty;
  entry_t                push_entry;
  entry_t                head;

  assign target = branch_addr_i & ALIGN_MASK;
  assign pop    = instr_valid_o & instr_ready_i;

  // Occupancy counts buffered words plus the one in flight; a pop this cycle
  // frees a slot early so streaming runs at one word per cycle.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q);
  assign limit     = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
  assign room      = occupancy < limit;

  // A branch always gets its own request out in the same cycle (the buffer
  // and in-flight slot are being discarded, so room is guaranteed).
  assign ram_en_o   = rst_n & fetch_en_i & (branch_i | room);
  assign ram_addr_o = branch_i ? target : pc_q;

  assign ram_we_o    = 1'b0;
  assign ram_be_o    = '1;
  assign ram_wdata_o = '0;

  // A response arriving in a branch cycle belongs to the old stream.
  assign push            = inflight_q & ~branch_i;
  assign push_entry.addr = req_addr_q;
  assign push_entry.data = ram_rdata_i;

  // Track the outstanding request and advance the PC. Any request (normal or
  // branch) moves pc to the word after the address just issued; a branch
  // without fetch enable parks pc on the target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= BOOT_ADDR;
      inflight_q <= 1'b0;
      req_addr_q <= '0;
    end else begin
      inflight_q <= ram_en_o;
      if (ram_en_o) begin
        req_addr_q <= ram_addr_o;
        pc_q       <= ram_addr_o + STRIDE_A;
      end else if (branch_i) begin
        pc_q <= target;
      end
    end
  end

  instr_fifo0 #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (branch_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (count)
  );

  assign instr_valid_o = ~fifo_empty;
  assign instr_rdata_o = fifo_empty ? '0 : head.data;
  assign instr_addr_o  = fifo_empty ? '0 : head.addr;

endmodule

// File: doc/instr_fetch_pref0.md
Name: instr_fetch_pref0

Overview:
- Initiator side of the instruction RAM port.
- Issues word reads to the instruction RAM wrapper (en/addr, fixed 1-cycle read latency, boot ROM selected by addr MSB) and buffers returned words in a small FIFO.
- Presents buffered words to the core through a valid/ready interface.
- Handles core redirects (branch/jump) by flushing buffered and in-flight data and refetching from the new address.

Parameters:
- ADDR_WIDTH, 16, byte address width of the RAM port; MSB=1 selects the boot ROM.
- DATA_WIDTH, 32, instruction word width; fetch stride is DATA_WIDTH/8 bytes.
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, minimum 2.
- BOOT_ADDR, 16'h8000, fetch PC after reset (boot ROM base).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- fetch_en_i  in  1  enables issuing new requests
- branch_i  in  1  redirect strobe, single cycle
- branch_addr_i  in  ADDR_WIDTH  redirect target; low log2(DATA_WIDTH/8) bits ignored (forced 0)
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  core accepts head
- instr_rdata_o  out  DATA_WIDTH  head instruction word
- instr_addr_o  out  ADDR_WIDTH  byte address of head word
- ram_en_o  out  1  read request
- ram_addr_o  out  ADDR_WIDTH  request byte address
- ram_we_o  out  1  constant 0
- ram_be_o  out  DATA_WIDTH/8  constant all ones
- ram_wdata_o  out  DATA_WIDTH  constant 0
- ram_rdata_i  in  DATA_WIDTH  read data, valid the cycle after ram_en_o

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active-low.
- Reset (sampled on a clk edge with rst_n=0):
  - pc=BOOT_ADDR; FIFO empty; inflight=0; instr_valid_o=0; ram_en_o=0.
  - instr_rdata_o=0 and instr_addr_o=0 while the FIFO is empty.
  - Any response due the cycle after reset is dropped.
- Request issue:
  - ram_en_o is combinational: fetch_en_i & ~branch_i & (count + inflight - pop < FIFO_DEPTH).
  - pop = instr_valid_o & instr_ready_i.
  - ram_addr_o = pc.
  - On issue: pc += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH (crossing into the boot ROM half is legal); inflight is set next cycle together with the request address.
- Response capture: when inflight=1, ram_rdata_i and the recorded request address are pushed into the FIFO at the next clk edge, unless the response is cancelled. inflight never exceeds 1.
- Throughput: 1 word/cycle sustained while the core is always ready and fetch_en_i=1.
- Latency: first instr_valid_o occurs 2 cycles after the first request (request at cycle 0, push at edge 1, visible from cycle 2).
- FIFO:
  - Simultaneous push and pop at any count is legal; count is unchanged.
  - Full: no issue unless a pop occurs this cycle. Overflow is impossible by construction; assert it.
- Redirect (branch_i=1):
  - At the edge: FIFO cleared, pending response cancelled, pc=aligned(branch_addr_i)+stride.
  - The same cycle, ram_en_o=1 with ram_addr_o=aligned(branch_addr_i) if fetch_en_i=1. This request is the single exception to the rule that ram_en_o is suppressed when branch_i=1.
  - If fetch_en_i=0, pc=aligned(branch_addr_i) and nothing is issued.
  - instr_valid_o is still driven from the old head during the branch cycle; the core must ignore it, and any pop in that cycle has no effect.
- Back-to-back branches: the last one wins; each cancels the previous one's response.
- fetch_en_i deasserted: stops new issues only. An in-flight response is still captured and the FIFO keeps draining.
- Mid-operation reset: all state is cleared on the next edge regardless of in-flight activity.

Decomposition:
- Shared package instr_fetch_pkg0: localparams BYTES_PER_WORD and WORD_OFFSET_BITS (= log2 of bytes per word); typedef fifo_entry_t {addr, data}.
- One sub-module, instr_fifo0: synchronous FIFO with flush_i, push/pop, count_o, parameterized by DEPTH and entry type.
- The top level holds pc, the inflight/cancel flag, issue logic, and the constant RAM write-side ties.

Test Plan:
- Reset then fetch_en_i=1, core always ready, RAM returns data=addr -> requests at 0x8000, 0x8004, 0x8008…; first valid at cycle 2 with addr 0x8000/data 0x8000; then 1 word per cycle.
- Core ready held 0 -> exactly FIFO_DEPTH=4 requests issued, ram_en_o stays 0 afterwards. Release ready -> words 0x8000..0x800C in order, then streaming resumes with no gap or duplicate.
- branch_i to 0x0102 while the FIFO holds 3 entries and one request is in flight -> same cycle ram_addr_o=0x0100; old entries and in-flight word never appear; next valid word has addr 0x0100.
- Branches on two consecutive cycles to 0x0200 then 0x0300 -> the only delivered stream starts at 0x0300.
- pc at 0xFFFC with ADDR_WIDTH=16 -> next request at 0x0000.
- rst_n=0 for 1 cycle while the FIFO is full and a request is in flight -> instr_valid_o=0 next cycle; first request after release is at 0x8000.
